// File: rtl/zigzag_scan_pkg.sv
// Shared JPEG constants and the zigzag scan order used by the zigzag stage.
// Provides coefficient/row widths, row/address types and the ZZ lookup function.
// Pure definitions; no logic, no latency, no flow control.
package zigzag_scan_pkg;

  localparam int COEF_W        = 10;
  localparam int COEFS_PER_ROW = 8;
  localparam int BLOCK_SIZE    = 64;
  localparam int ROW_W         = COEF_W * COEFS_PER_ROW;
  localparam int ADDR_W        = 6;

  typedef logic [ROW_W-1:0]                  row_t;
  typedef logic [COEF_W-1:0]                 coef_t;
  typedef logic [ADDR_W-1:0]                 addr_t;
  // Eight raster addresses, address k at bits [ADDR_W*(8-k)-1 -: ADDR_W].
  typedef logic [COEFS_PER_ROW*ADDR_W-1:0]   addr_vec_t;

  // Standard JPEG zigzag order: entry i is the raster address of scan index i.
  localparam int ZZ_TAB [BLOCK_SIZE] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic addr_t zz(input addr_t idx);
    return addr_t'(ZZ_TAB[idx]);
  endfunction

endpackage

// File: rtl/zigzag_scan_if.sv
// Row-in / zigzag-group-out stream bundle between raster source, zigzag stage and RLE.
// Signals: in_data/in_valid/in_ready (raster rows), out_data/out_valid/out_ready,
// out_first/out_last (zigzag groups). slave = zigzag stage side, master = source/sink side.
interface zigzag_scan_if;
  import zigzag_scan_pkg::*;

  row_t in_data;
  logic in_valid;
  logic in_ready;
  row_t out_data;
  logic out_valid;
  logic out_ready;
  logic out_first;
  logic out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last
  );

endinterface

// File: rtl/zigzag_scan_bank.sv
// zigzag_bank: one 8x8 block of 10-bit coefficients, row-wide write, 8 random reads.
// Ports: clk, we/wrow/wdata (write row wrow), raddr/rdata (8 combinational reads).
// Write lands on the clock edge; reads are combinational; no flow control here.
module zigzag_bank
  import zigzag_scan_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  logic [2:0] wrow,
  input  row_t      wdata,
  input  addr_vec_t raddr,
  output row_t      rdata
);

  // Contents are deliberately unreset: the owner's full flag gates visibility.
  coef_t mem [BLOCK_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < COEFS_PER_ROW; c++) begin
        mem[{wrow, 3'(c)}] <= wdata[ROW_W-1-COEF_W*c -: COEF_W];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < COEFS_PER_ROW; k++) begin
      rdata[ROW_W-1-COEF_W*k -: COEF_W] = mem[raddr[ADDR_W*(COEFS_PER_ROW-k)-1 -: ADDR_W]];
    end
  end

endmodule

// File: rtl/zigzag_scan.sv
// zigzag_scan: reorders 8x8 raster blocks into 8 zigzag groups of 8 coefficients.
// Latency: group 0 valid the cycle after row 7 is accepted; 1 row in + 1 group out per cycle.
// Backpressure: ping-pong banks; in_ready drops only when both banks hold unread blocks.
// Ports: clk, reset (async active-low), bus (zigzag_scan_if.slave).
module zigzag_scan
  import zigzag_scan_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  zigzag_scan_if.slave    bus
);

  logic [1:0] full;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [2:0] row_cnt;
  logic [2:0] grp_cnt;

  logic       in_fire;
  logic       out_fire;
  addr_vec_t  raddr;
  row_t       bank_rd [2];

  assign bus.in_ready  = ~full[wr_ptr];
  assign bus.out_valid = full[rd_ptr];
  assign bus.out_first = (grp_cnt == 3'd0);
  assign bus.out_last  = (grp_cnt == 3'd7);
  assign bus.out_data  = bank_rd[rd_ptr];

  assign in_fire  = bus.in_valid  & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Both banks see the same group addresses; only the read-pointer bank is muxed out.
  always_comb begin
    raddr = '0;
    for (int k = 0; k < COEFS_PER_ROW; k++) begin
      raddr[ADDR_W*(COEFS_PER_ROW-k)-1 -: ADDR_W] = zz({grp_cnt, 3'(k)});
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    zigzag_bank u_bank (
      .clk   (clk),
      .we    (in_fire && (wr_ptr == 1'(b))),
      .wrow  (row_cnt),
      .wdata (bus.in_data),
      .raddr (raddr),
      .rdata (bank_rd[b])
    );
  end

  // A fill only targets a non-full bank and a drain only a full one, so the
  // set and clear of full[] on the same edge always address different bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full    <= 2'b00;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      row_cnt <= 3'd0;
      grp_cnt <= 3'd0;
    end else begin
      if (in_fire) begin
        row_cnt <= row_cnt + 3'd1;
        if (row_cnt == 3'd7) begin
          full[wr_ptr] <= 1'b1;
          wr_ptr       <= ~wr_ptr;
        end
      end
      if (out_fire) begin
        grp_cnt <= grp_cnt + 3'd1;
        if (grp_cnt == 3'd7) begin
          full[rd_ptr] <= 1'b0;
          rd_ptr       <= ~rd_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_zigzag_scan.sv
// Scoreboard bench for zigzag_scan: directed blocks, expected groups queued at issue.
// Monitor pops and compares on every accepted group, and checks stall stability.
// Covers reset, latency, back-to-back, full backpressure, extremes, mid-block reset.
module tb_zigzag_scan;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  zigzag_scan_if bus ();

  zigzag_scan dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [79:0] data;
    logic        first;
    logic        last;
  } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t sb [$];

  int ZZT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic [9:0] cur [64];
  int in_stalls = 0;
  int run = 0;
  int max_run = 0;
  logic held = 1'b0;
  logic [79:0] held_data;
  logic held_first, held_last;
  exp_t e;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted group against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      held = 1'b0;
      run  = 0;
    end else begin
      if (held && bus.out_valid) begin
        chk("stall_data",  bus.out_data,  held_data);
        chk("stall_first", bus.out_first, held_first);
        chk("stall_last",  bus.out_last,  held_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        run++;
        if (run > max_run) max_run = run;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_group: got %h expected none", bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("group_data",  bus.out_data,  e.data);
          chk("group_first", bus.out_first, e.first);
          chk("group_last",  bus.out_last,  e.last);
        end
      end else begin
        run = 0;
      end
      held = bus.out_valid && !bus.out_ready;
      if (held) begin
        held_data  = bus.out_data;
        held_first = bus.out_first;
        held_last  = bus.out_last;
      end
    end
  end

  task automatic push_expected();
    exp_t x;
    for (int g = 0; g < 8; g++) begin
      x.data = '0;
      for (int k = 0; k < 8; k++) x.data[79-10*k -: 10] = cur[ZZT[8*g+k]];
      x.first = (g == 0);
      x.last  = (g == 7);
      sb.push_back(x);
    end
  endtask

  function automatic logic [79:0] row_of(input int r);
    logic [79:0] d;
    d = '0;
    for (int c = 0; c < 8; c++) d[79-10*c -: 10] = cur[8*r+c];
    return d;
  endfunction

  // Offer one row and return #1 after the edge that accepted it; in_valid stays high.
  task automatic send_row(input int r);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = row_of(r);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      in_stalls++;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL row_timeout: row %0d never accepted", r);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_block();
    push_expected();
    for (int r = 0; r < 8; r++) send_row(r);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(name, sb.size(), 0);
  endtask

  initial begin
    int early;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_first", bus.out_first, 1);
    chk("rst_out_last",  bus.out_last,  0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Raster-index block: latency and hand-computed group 0.
    for (int i = 0; i < 64; i++) cur[i] = 10'(i);
    bus.out_ready = 1'b1;
    push_expected();
    for (int r = 0; r < 7; r++) send_row(r);
    chk("lat_before_row7", bus.out_valid, 0);
    send_row(7);
    bus.in_valid = 1'b0;
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_group0", bus.out_data,
        {10'd0, 10'd1, 10'd8, 10'd16, 10'd9, 10'd2, 10'd3, 10'd10});
    chk("lat_first", bus.out_first, 1);
    wait_empty("drain_raster");

    // Three blocks back to back at full rate.
    in_stalls = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) cur[i] = 10'((b * 97 + i * 13 + 5) & 10'h3FF);
      send_block();
    end
    bus.in_valid = 1'b0;
    wait_empty("drain_b2b");
    chk("b2b_in_stalls", in_stalls, 0);
    chk("b2b_run_len", max_run, 24);

    // Both banks full: 17th row waits for block 1 to drain.
    bus.out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) cur[i] = 10'((b * 211 + i * 3 + 100) & 10'h3FF);
      send_block();
    end
    chk("full_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 64; i++) cur[i] = 10'((1023 - i * 5) & 10'h3FF);
    push_expected();
    bus.in_valid = 1'b1;
    bus.in_data  = row_of(0);
    repeat (3) @(posedge clk);
    #1;
    chk("full_hold_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.in_ready) early++;
    end
    chk("row17_early", early, 0);
    @(negedge clk);
    chk("row17_accept", bus.in_ready, 1);
    @(posedge clk);
    #1;
    for (int r = 1; r < 8; r++) send_row(r);
    bus.in_valid = 1'b0;
    wait_empty("drain_full");

    // Extremes: all -1, then -512 at the last raster address.
    for (int i = 0; i < 64; i++) cur[i] = 10'h3FF;
    send_block();
    for (int i = 0; i < 64; i++) cur[i] = 10'(i);
    cur[63] = 10'h200;
    send_block();
    bus.in_valid = 1'b0;
    wait_empty("drain_extreme");

    // Reset after 5 rows of block A: nothing of A may ever appear.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) cur[i] = 10'h155;
    for (int r = 0; r < 5; r++) send_row(r);
    bus.in_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready",  bus.in_ready,  1);
    chk("midrst_out_first", bus.out_first, 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) cur[i] = 10'((i * 29 + 7) & 10'h3FF);
    send_block();
    bus.in_valid = 1'b0;
    wait_empty("drain_after_reset");

    // Random out_ready stalls during drains.
    fork
      begin
        for (int b = 0; b < 2; b++) begin
          for (int i = 0; i < 64; i++) cur[i] = 10'((b * 331 + i * 41) & 10'h3FF);
          send_block();
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk);
          #1;
          bus.out_ready = (i % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_empty("drain_random");
    chk("end_out_valid", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zigzag_scan.md
ZIGZAG_SCAN -- requirements
Module: zigzag_scan

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; clears all state immediately while low.
REQ-003 in_data  input  80  one raster row of quantized coefficients, 8 x 10-bit two's complement; column c at bits [79-10c -: 10].
REQ-004 in_valid  input  1  in_data holds a valid row.
REQ-005 in_ready  output  1  block accepts a row this cycle.
REQ-006 out_data  output  80  8 coefficients in zigzag order; k-th coefficient of the group at bits [79-10k -: 10]; this is the row format the RLE stage consumes.
REQ-007 out_valid  output  1  out_data holds a valid zigzag group.
REQ-008 out_ready  input  1  downstream RLE stage accepts the group.
REQ-009 out_first  output  1  high with group 0 of a block (zigzag indices 0..7).
REQ-010 out_last  output  1  high with group 7 of a block (zigzag indices 56..63).

Function
REQ-011 A transfer occurs on a rising edge where valid and ready are both high; no other condition moves data.
REQ-012 Storage is two 64 x 10-bit banks (ping-pong) with per-bank full flags, a write-bank pointer, a read-bank pointer, a 3-bit write row counter and a 3-bit read group counter.
REQ-013 in_ready is high exactly when the bank under the write pointer is not full.
REQ-014 An accepted row r writes columns 0..7 to raster addresses 8r..8r+7 of the write bank, then increments r.
REQ-015 Accepting row 7 sets that bank's full flag, wraps r to 0 and toggles the write pointer, all on the same edge.
REQ-016 out_valid is high exactly when the bank under the read pointer is full.
REQ-017 Coefficient k of group g is read combinationally from raster address ZZ[8g+k] of the read bank, where ZZ is the standard JPEG zigzag table: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
REQ-018 An accepted group increments g; accepting group 7 clears that bank's full flag, wraps g to 0 and toggles the read pointer.
REQ-019 Coefficient values pass through bit-exact with no arithmetic or sign change.
REQ-020 Latency: out_valid rises in the cycle after the edge that accepts row 7, with group 0 on out_data.
REQ-021 Throughput: with in_valid and out_ready held high, the block sustains one row in and one group out per cycle with no bubbles after the first block.
REQ-022 A fill of one bank and a drain of the other on the same edge are both performed.
REQ-023 While both banks are full, in_ready is low and in_data is ignored.
REQ-024 While out_valid is high and out_ready is low, out_data, out_first and out_last hold stable.

Reset
REQ-025 While reset is low, all of the following are cleared: both full flags, both pointers, r and g. As a result, in_ready=1, out_valid=0, out_first=1 and out_last=0.
REQ-026 Bank contents are not reset; they are never visible while the associated full flag is clear.
REQ-027 Reset asserted mid-block discards all partial and complete blocks; the first row accepted after reset release is row 0 of a new block.

Structure
REQ-028 The shared JPEG package holds COEF_W=10, COEFS_PER_ROW=8, BLOCK_SIZE=64 and the 64-entry ZZ table as a constant function.
REQ-029 One sub-module, zigzag_bank (64 x 10 register array with 8-wide row write and 8 independent read addresses), is instantiated twice.

Verification
REQ-030 Block with coef = raster index 0..63, out_ready=1 -> group 0 = {0,1,8,16,9,2,3,10}, out_first=1; group 7 = {53,60,61,54,47,55,62,63}, out_last=1; out_valid rises one cycle after row 7.
REQ-031 Three blocks back-to-back, in_valid=out_ready=1 -> 24 consecutive out_valid cycles, out_first every 8th beat, in_ready never low.
REQ-032 out_ready=0, 17 rows offered -> in_ready falls after row 16 is accepted; row 17 is accepted only on the edge after group 7 of block 1 is taken.
REQ-033 All coefficients = -1 (10'h3FF), or -512 (10'h200) at raster address 63 -> values reproduced bit-exact; 10'h200 appears at group 7, k=7.
REQ-034 Reset pulsed low after 5 rows of block A -> out_valid=0 and in_ready=1 immediately; the next 8 rows (block B) emit only block B data.
REQ-035 out_ready toggling 1-0-1 in random patterns during a drain -> out_data stable while stalled, and no group is dropped or duplicated.
